dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's memory-stage interface; the pipeline issues load/store requests, this block serves them.
- Holds a word-organised RAM and inserts a programmable number of wait states per access.
- Stalls the initiator with mem_stall until the access completes, then returns read data.
- Sits between the memory stage and the writeback register.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the RAM; power of two.
- WAIT_CYCLES, 2, wait states per access; legal range 1..15.

Ports:
- CLK_50  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  access request: MemWriteM or load in M stage.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address (ALU result of M stage).
- req_wdata  in  32  store data.
- mem_stall  out  1  hold the pipeline; the request is not yet complete.
- rdata  out  32  load data; valid while rd_valid = 1.
- rd_valid  out  1  one-cycle pulse: a load completed.
- addr_err  out  1  one-cycle pulse: request was misaligned or out of range.

Behaviour:
- Reset (reset = 0, asynchronous) sets:
  - state = IDLE, wait counter = 0, captured request regs = 0;
  - rdata = 0, rd_valid = 0, addr_err = 0, mem_stall = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-access aborts the access; a store not yet committed is discarded.
- FSM states IDLE, BUSY, DONE:
  - IDLE: if req_valid = 1, mem_stall = 1 combinationally. At the clock edge, capture req_we/req_addr/req_wdata, load counter = WAIT_CYCLES-1, go to BUSY.
  - BUSY: mem_stall = 1 regardless of req_valid. Each edge decrements the counter. At the edge where counter = 0, perform the access and go to DONE.
    - Store: RAM word written at that edge.
    - Load: RAM word registered into rdata at that edge.
  - DONE: mem_stall = 0; rd_valid = 1 if the captured op was a load; addr_err = 1 if the captured request was illegal. Next edge goes to IDLE.
- Latency:
  - mem_stall is high for exactly WAIT_CYCLES+1 cycles per request.
  - rdata and rd_valid appear in the first unstalled cycle (DONE).
  - Back-to-back requests: the next request is accepted in the IDLE cycle after DONE.
- Captured values are used throughout. Input changes while stalled are ignored. req_valid dropping during BUSY does not cancel the access.
- Word index = captured addr[log2(DEPTH_WORDS)+1:2].
- Illegal request: addr[1:0] != 0, or addr >= 4*DEPTH_WORDS.
  - Store is suppressed.
  - Load returns rdata = 0 with rd_valid = 1.
  - addr_err pulses in DONE.
- rdata holds its last value outside DONE.

Optional Feature:
- Macro: DMEM_BYTE_ACCESS_EN.
- When defined:
  - Extra input req_byte (1 bit) is added and captured with the request.
  - Byte stores write only lane addr[1:0]; other lanes are preserved (read-modify-write inside the DONE-transition edge).
  - Byte loads return that lane zero-extended.
  - Only out-of-range addresses are illegal for byte accesses.
- When undefined: no req_byte port, word accesses only, misalignment rules as above.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with req_valid = 1 -> mem_stall = 0, rdata = 0, rd_valid = 0, addr_err = 0.
- Store then load, WAIT_CYCLES = 2:
  - Store 0xDEADBEEF to 0x10 -> mem_stall high for 3 cycles.
  - Load 0x10 -> rdata = 0xDEADBEEF, rd_valid pulse in cycle 4.
- Input change mid-stall: store to 0x20 with data 0x1; change req_addr to 0x24 and req_wdata to 0x2 during BUSY -> word 8 = 0x1, word 9 unchanged.
- Illegal accesses:
  - Store to 0x13 -> addr_err pulse, RAM unchanged.
  - Load from 0x100 (DEPTH_WORDS = 64) -> rdata = 0, rd_valid = 1, addr_err = 1.
- Reset mid-access: assert reset in the second BUSY cycle of a store of 0xA5A5A5A5 to 0x04 -> word 1 keeps its prior value; state returns to IDLE.
- With DMEM_BYTE_ACCESS_EN: word 0x11223344 at 0x08; byte store 0xFF to 0x09 -> word reads 0x1122FF44; byte load 0x0B -> rdata = 0x00000011.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with programmable wait states
//
// Purpose: serves memory-stage load/store requests from a word-organised RAM.
//   Each accepted request is held for WAIT_CYCLES wait states and then
//   completes in a one-cycle DONE state. The RAM is not cleared by reset.
// Optional feature macro: DMEM_BYTE_ACCESS_EN (adds req_byte, byte-lane access).
// Ports:
//   CLK_50     in   clock, rising edge
//   reset      in   asynchronous active-low reset
//   req_valid  in   access request
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   req_byte   in   byte access (only with DMEM_BYTE_ACCESS_EN)
//   mem_stall  out  hold the pipeline, request not yet complete
//   rdata      out  load data, valid while rd_valid = 1, holds otherwise
//   rd_valid   out  one-cycle pulse, a load completed
//   addr_err   out  one-cycle pulse, request was misaligned or out of range
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK_50,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_ACCESS_EN
  input  logic        req_byte,
`endif
  output logic        mem_stall,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic        addr_err_q, addr_err_d;
`ifdef DMEM_BYTE_ACCESS_EN
  logic        byte_q, byte_d;
`endif

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          illegal;
  logic          access;
  logic          mem_we;
  logic [31:0]   cur_word;
  logic [31:0]   load_data;
  logic [31:0]   store_word;

  assign idx          = addr_q[AW+1:2];
  assign lane         = addr_q[1:0];
  // Power-of-two depth: any set bit above the RAM span means addr >= 4*DEPTH_WORDS.
  assign out_of_range = |addr_q[31:AW+2];
  assign access       = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_we       = access && we_q && !illegal;
  assign cur_word     = mem[idx];

`ifdef DMEM_BYTE_ACCESS_EN
  assign illegal = out_of_range || (!byte_q && (lane != 2'd0));

  always_comb begin
    load_data  = cur_word;
    store_word = wdata_q;
    if (byte_q) begin
      load_data                     = {24'd0, cur_word[{lane, 3'b000} +: 8]};
      // Read-modify-write: untouched lanes keep their current contents.
      store_word                    = cur_word;
      store_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
    end
  end
`else
  assign illegal    = out_of_range || (lane != 2'd0);
  assign load_data  = cur_word;
  assign store_word = wdata_q;
`endif

  // Stall is combinational in IDLE so the initiator holds in the request cycle.
  assign mem_stall = reset && (((state_q == IDLE) && req_valid) || (state_q == BUSY));
  assign rdata     = rdata_q;
  assign rd_valid  = rd_valid_q;
  assign addr_err  = addr_err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    addr_err_d = 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
    byte_d     = byte_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef DMEM_BYTE_ACCESS_EN
          byte_d  = req_byte;
`endif
          cnt_d   = 4'(WAIT_CYCLES - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = DONE;
          rd_valid_d = !we_q;
          addr_err_d = illegal;
          if (!we_q) begin
            rdata_d = illegal ? 32'd0 : load_data;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
`ifdef DMEM_BYTE_ACCESS_EN
      byte_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
`ifdef DMEM_BYTE_ACCESS_EN
      byte_q     <= byte_d;
`endif
    end
  end

  // RAM has no reset; a store is dropped if reset is low at its commit edge.
  always_ff @(posedge CLK_50) begin
    if (mem_we && reset) begin
      mem[idx] <= store_word;
    end
  end

endmodule
